// File: rtl/pcie_phy_pkg.sv
// Shared types for the PHY receive path: arbiter states, source encodings, round-robin pick.
// Optional macro PHY_RX_ARB_ABORT_EN adds the ABORT state.
package pcie_phy_pkg;

`ifdef PHY_RX_ARB_ABORT_EN
    typedef enum logic [2:0] {IDLE, GNT_DLLP, GNT_TLP, FLUSH, ABORT} arb_state_e;
`else
    typedef enum logic [1:0] {IDLE, GNT_DLLP, GNT_TLP, FLUSH} arb_state_e;
`endif

    localparam logic SRC_DLLP = 1'b0;
    localparam logic SRC_TLP  = 1'b1;

    // On a tie the source that did not win last time gets the grant
    function automatic logic rr_pick(input logic dllp_valid, input logic tlp_valid,
                                     input logic last_grant);
        if (dllp_valid && tlp_valid) return ~last_grant;
        else if (tlp_valid)          return SRC_TLP;
        else                         return SRC_DLLP;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream register slice with source tag; clear drops the held beat.
module axis_reg_slice #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [KEEP_WIDTH-1:0] in_keep,
    input  logic                  in_last,
    input  logic [USER_WIDTH-1:0] in_user,
    input  logic                  in_src,
    output logic                  in_ready_c,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic                  out_last,
    output logic [USER_WIDTH-1:0] out_user,
    output logic                  out_src,
    input  logic                  out_ready
);

    assign in_ready_c = !out_valid || out_ready;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_user  <= '0;
            out_src   <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (in_ready_c) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                out_keep <= in_keep;
                out_last <= in_last;
                out_user <= in_user;
                out_src  <= in_src;
            end
        end
    end

endmodule

// File: rtl/phy_rx_stream_arbiter.sv
// Packet round-robin merge of receive DLLP and TLP streams with link-down flush.
// Optional macro PHY_RX_ARB_ABORT_EN: emit one abort beat before flushing an interrupted packet.
module phy_rx_stream_arbiter
    import pcie_phy_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 5,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  link_up_i,
    input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
    input  logic                  s_dllp_axis_tvalid,
    input  logic                  s_dllp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_dllp_axis_tuser,
    output logic                  s_dllp_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_tlp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tlp_axis_tkeep,
    input  logic                  s_tlp_axis_tvalid,
    input  logic                  s_tlp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_tlp_axis_tuser,
    output logic                  s_tlp_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  m_axis_src_o,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  dllp_count_o,
    output logic [CNT_WIDTH-1:0]  tlp_count_o
);

    arb_state_e            state_q, state_d;
    logic                  last_grant_q;
    logic                  out_ready_c;
    logic                  sel_dllp, sel_tlp, flush_rdy;
    logic                  acc_dllp, acc_tlp;
    logic                  ld_valid, ld_last, ld_src;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [KEEP_WIDTH-1:0] ld_keep;
    logic [USER_WIDTH-1:0] ld_user;
    logic                  flush_c;
`ifdef PHY_RX_ARB_ABORT_EN
    logic                  abort_sent_q, abort_src_q, abort_ld;
`endif

    // State register plus the round-robin memory
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_TLP;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (acc_dllp || acc_tlp))
                last_grant_q <= acc_tlp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dllp_count_o <= '0;
            tlp_count_o  <= '0;
        end else begin
            if (acc_dllp && s_dllp_axis_tlast) dllp_count_o <= dllp_count_o + CNT_WIDTH'(1);
            if (acc_tlp && s_tlp_axis_tlast)   tlp_count_o  <= tlp_count_o + CNT_WIDTH'(1);
        end
    end

`ifdef PHY_RX_ARB_ABORT_EN
    // Abort bookkeeping: remember the interrupted source and whether its abort beat is loaded
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            abort_sent_q <= 1'b0;
            abort_src_q  <= SRC_DLLP;
        end else if (state_q != ABORT) begin
            abort_sent_q <= 1'b0;
            abort_src_q  <= (state_q == GNT_TLP);
        end else if (abort_ld) begin
            abort_sent_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!link_up_i)                          state_d = FLUSH;
                else if (acc_dllp && !s_dllp_axis_tlast) state_d = GNT_DLLP;
                else if (acc_tlp && !s_tlp_axis_tlast)   state_d = GNT_TLP;
            end
            GNT_DLLP, GNT_TLP: begin
                if (!link_up_i) begin
`ifdef PHY_RX_ARB_ABORT_EN
                    state_d = ABORT;
`else
                    state_d = FLUSH;
`endif
                end else if ((acc_dllp && s_dllp_axis_tlast) || (acc_tlp && s_tlp_axis_tlast)) begin
                    state_d = IDLE;
                end
            end
            FLUSH: if (link_up_i) state_d = IDLE;
`ifdef PHY_RX_ARB_ABORT_EN
            ABORT: if (abort_sent_q && m_axis_tvalid && m_axis_tready) state_d = FLUSH;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Grant, ready and load mux for the output slice
    always_comb begin
        sel_dllp  = 1'b0;
        sel_tlp   = 1'b0;
        flush_rdy = 1'b0;
`ifdef PHY_RX_ARB_ABORT_EN
        abort_ld  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (link_up_i && (s_dllp_axis_tvalid || s_tlp_axis_tvalid)) begin
                    if (rr_pick(s_dllp_axis_tvalid, s_tlp_axis_tvalid, last_grant_q) == SRC_TLP)
                        sel_tlp = 1'b1;
                    else
                        sel_dllp = 1'b1;
                end
            end
            GNT_DLLP: sel_dllp  = link_up_i;
            GNT_TLP:  sel_tlp   = link_up_i;
            FLUSH:    flush_rdy = 1'b1;
`ifdef PHY_RX_ARB_ABORT_EN
            ABORT:    abort_ld  = !abort_sent_q && out_ready_c;
`endif
            default: ;
        endcase

        s_dllp_axis_tready = rst_n_i && (flush_rdy || (sel_dllp && out_ready_c));
        s_tlp_axis_tready  = rst_n_i && (flush_rdy || (sel_tlp && out_ready_c));
        acc_dllp = sel_dllp && s_dllp_axis_tvalid && out_ready_c;
        acc_tlp  = sel_tlp && s_tlp_axis_tvalid && out_ready_c;

        ld_valid = acc_dllp || acc_tlp;
        ld_src   = sel_tlp;
        ld_data  = sel_tlp ? s_tlp_axis_tdata : s_dllp_axis_tdata;
        ld_keep  = sel_tlp ? s_tlp_axis_tkeep : s_dllp_axis_tkeep;
        ld_last  = sel_tlp ? s_tlp_axis_tlast : s_dllp_axis_tlast;
        ld_user  = sel_tlp ? s_tlp_axis_tuser : s_dllp_axis_tuser;
`ifdef PHY_RX_ARB_ABORT_EN
        if (state_q == ABORT) begin
            ld_valid = abort_ld;
            ld_src   = abort_src_q;
            ld_data  = '0;
            ld_keep  = '0;
            ld_last  = 1'b1;
            ld_user  = USER_WIDTH'(1);
        end
`endif
    end

    assign flush_c = (state_d == FLUSH);

    axis_reg_slice #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH),
        .USER_WIDTH(USER_WIDTH)
    ) u_out_slice (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clear      (flush_c),
        .in_valid   (ld_valid),
        .in_data    (ld_data),
        .in_keep    (ld_keep),
        .in_last    (ld_last),
        .in_user    (ld_user),
        .in_src     (ld_src),
        .in_ready_c (out_ready_c),
        .out_valid  (m_axis_tvalid),
        .out_data   (m_axis_tdata),
        .out_keep   (m_axis_tkeep),
        .out_last   (m_axis_tlast),
        .out_user   (m_axis_tuser),
        .out_src    (m_axis_src_o),
        .out_ready  (m_axis_tready)
    );

endmodule

// File: tb/tb_phy_rx_stream_arbiter.sv
// Scoreboard bench for phy_rx_stream_arbiter; per-source expected queues checked at the output handshake.
module tb_phy_rx_stream_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned KW = 4;
    localparam int unsigned UW = 5;
    localparam int unsigned CW = 4;

    typedef logic [41:0] beat_t;   // {data, keep, last, user}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          link_up = 1'b1;
    logic [DW-1:0] d_tdata = '0, t_tdata = '0, m_tdata;
    logic [KW-1:0] d_tkeep = '0, t_tkeep = '0, m_tkeep;
    logic          d_tvalid = 1'b0, t_tvalid = 1'b0, m_tvalid;
    logic          d_tlast = 1'b0, t_tlast = 1'b0, m_tlast;
    logic [UW-1:0] d_tuser = '0, t_tuser = '0, m_tuser;
    logic          d_tready, t_tready, m_src;
    logic          m_tready = 1'b1;
    logic [CW-1:0] dllp_cnt, tlp_cnt;

    beat_t exp_dllp_q[$];
    beat_t exp_tlp_q[$];
    int    out_log[$];
    int    acc_log[$];
    bit    order_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    phy_rx_stream_arbiter #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .link_up_i(link_up),
        .s_dllp_axis_tdata(d_tdata), .s_dllp_axis_tkeep(d_tkeep), .s_dllp_axis_tvalid(d_tvalid),
        .s_dllp_axis_tlast(d_tlast), .s_dllp_axis_tuser(d_tuser), .s_dllp_axis_tready(d_tready),
        .s_tlp_axis_tdata(t_tdata), .s_tlp_axis_tkeep(t_tkeep), .s_tlp_axis_tvalid(t_tvalid),
        .s_tlp_axis_tlast(t_tlast), .s_tlp_axis_tuser(t_tuser), .s_tlp_axis_tready(t_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_src_o(m_src),
        .m_axis_tready(m_tready), .dllp_count_o(dllp_cnt), .tlp_count_o(tlp_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] d, input int i, input int n);
        logic last;
        last = (i == n - 1);
        return {d, (last ? 4'h3 : 4'hF), last, UW'(d[4:0] ^ 5'(i))};
    endfunction

    function automatic logic [15:0] order_bits();
        logic [15:0] r;
        r = '0;
        foreach (order_q[i]) r = {r[14:0], order_q[i]};
        return r;
    endfunction

    task automatic clear_logs();
        out_log.delete();
        acc_log.delete();
        order_q.delete();
    endtask

    // Present an n-beat packet on one source; expected beats queued as they are driven
    task automatic send_pkt(input bit src, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            int    t;
            bit    ok;
            b = mk(base + 32'(i), i, n);
            if (src) begin
                {t_tdata, t_tkeep, t_tlast, t_tuser} = b;
                t_tvalid = 1'b1;
                exp_tlp_q.push_back(b);
            end else begin
                {d_tdata, d_tkeep, d_tlast, d_tuser} = b;
                d_tvalid = 1'b1;
                exp_dllp_q.push_back(b);
            end
            t  = 0;
            ok = 1'b0;
            while (!ok && t < 200) begin
                @(negedge clk);
                ok = src ? t_tready : d_tready;
                t++;
            end
            if (!ok) check("src_ready_timeout", 64'(ok), 64'd1);
            acc_log.push_back(cyc);
            @(posedge clk); #1;
        end
        if (src) t_tvalid = 1'b0;
        else     d_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_dllp_q.size() != 0 || exp_tlp_q.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk); #1;
        check("drain", 64'(exp_dllp_q.size() + exp_tlp_q.size()), 64'd0);
        exp_dllp_q.delete();
        exp_tlp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Output monitor: hold check under stall, scoreboard compare on handshake
    beat_t prev_b;
    logic  prev_src;
    bit    stall_prev = 1'b0;
    always @(negedge clk) begin
        beat_t cur, e;
        cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
        if (stall_prev && m_tvalid)
            check("hold", 64'({cur, m_src}), 64'({prev_b, prev_src}));
        if (m_tvalid && m_tready) begin
            e = '1;
            if (m_src && exp_tlp_q.size() != 0)        e = exp_tlp_q.pop_front();
            else if (!m_src && exp_dllp_q.size() != 0) e = exp_dllp_q.pop_front();
            check(m_src ? "tlp_beat" : "dllp_beat", 64'(cur), 64'(e));
            order_q.push_back(m_src);
            out_log.push_back(cyc);
        end
        stall_prev = m_tvalid && !m_tready;
        prev_b     = cur;
        prev_src   = m_src;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] d0, t0;
        int            t;
        beat_t         b;

        // Reset with a requester already valid: treadys must stay low
        rst_n = 1'b0;
        d_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_src", 64'(m_src), 64'd0);
        check("rst_payload", 64'({m_tdata, m_tkeep, m_tlast, m_tuser}), 64'd0);
        check("rst_dllp_cnt", 64'(dllp_cnt), 64'd0);
        check("rst_tlp_cnt", 64'(tlp_cnt), 64'd0);
        check("rst_dllp_rdy", 64'(d_tready), 64'd0);
        check("rst_tlp_rdy", 64'(t_tready), 64'd0);
        d_tvalid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single 2-beat DLLP, latency 1, full throughput
        clear_logs();
        send_pkt(1'b0, 2, 32'hA000_0010);
        drain();
        check("t1_nbeats", 64'(out_log.size()), 64'd2);
        if (out_log.size() >= 2 && acc_log.size() >= 2) begin
            check("t1_lat0", 64'(out_log[0] - acc_log[0]), 64'd1);
            check("t1_lat1", 64'(out_log[1] - acc_log[1]), 64'd1);
        end
        check("t1_dllp_cnt", 64'(dllp_cnt), 64'd1);
        check("t1_tlp_cnt", 64'(tlp_cnt), 64'd0);

        // Ties from reset: DLLP first, TLP with no bubble, then alternation
        do_reset();
        clear_logs();
        fork
            send_pkt(1'b1, 4, 32'h1000_0010);
            send_pkt(1'b0, 2, 32'h2000_0020);
        join
        fork
            begin
                send_pkt(1'b0, 1, 32'h2100_0001);
                send_pkt(1'b0, 1, 32'h2200_0002);
            end
            send_pkt(1'b1, 1, 32'h1100_0003);
        join
        drain();
        check("t2_order", 64'(order_bits()), 64'h07A);
        if (out_log.size() >= 6)
            check("t2_no_bubble", 64'(out_log[5] - out_log[0]), 64'd5);
        check("t2_dllp_cnt", 64'(dllp_cnt), 64'd3);
        check("t2_tlp_cnt", 64'(tlp_cnt), 64'd2);

        // Lock: DLLP request mid-TLP waits for TLP tlast
        clear_logs();
        fork
            send_pkt(1'b1, 4, 32'h3000_0000);
            begin
                repeat (2) @(posedge clk);
                #1;
                send_pkt(1'b0, 1, 32'h4000_0007);
            end
            begin
                repeat (3) @(negedge clk);
                check("t3_lock_rdy", 64'(d_tready), 64'd0);
            end
        join
        drain();
        check("t3_order", 64'(order_bits()), 64'h1E);
        if (out_log.size() >= 5)
            check("t3_next_cycle", 64'(out_log[4] - out_log[3]), 64'd1);

        // Back-pressure 1,0,0,1 during a 3-beat TLP
        clear_logs();
        t0 = tlp_cnt;
        fork
            send_pkt(1'b1, 3, 32'h5000_0004);
            begin
                @(posedge clk); #1; m_tready = 1'b0;
                @(posedge clk); #1; m_tready = 1'b0;
                @(posedge clk); #1; m_tready = 1'b1;
            end
        join
        drain();
        check("t4_nbeats", 64'(out_log.size()), 64'd3);
        check("t4_tlp_cnt", 64'(tlp_cnt), 64'(t0 + CW'(1)));

        // Link down on beat 2 of a 4-beat TLP with beat 1 stalled in the output stage
        clear_logs();
        d0 = dllp_cnt;
        t0 = tlp_cnt;
        b = mk(32'h6000_0008, 0, 4);
        {t_tdata, t_tkeep, t_tlast, t_tuser} = b;
        t_tvalid = 1'b1;
`ifdef PHY_RX_ARB_ABORT_EN
        exp_tlp_q.push_back(b);
`endif
        @(posedge clk); #1;
        m_tready = 1'b0;
        link_up  = 1'b0;
        {t_tdata, t_tkeep, t_tlast, t_tuser} = mk(32'h6000_0009, 1, 4);
`ifdef PHY_RX_ARB_ABORT_EN
        exp_tlp_q.push_back({32'd0, 4'd0, 1'b1, 5'b00001});
`endif
        @(posedge clk); #1;
        m_tready = 1'b1;
`ifndef PHY_RX_ARB_ABORT_EN
        @(negedge clk);
        check("t5_tvalid_drop", 64'(m_tvalid), 64'd0);
`endif
        t = 0;
        while (!(d_tready && t_tready) && t < 8) begin
            @(negedge clk);
            t++;
        end
        check("t5_flush_rdy", 64'({d_tready, t_tready}), 64'h3);
        check("t5_flush_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge clk); #1;
        check("t5_dllp_cnt", 64'(dllp_cnt), 64'(d0));
        check("t5_tlp_cnt", 64'(tlp_cnt), 64'(t0));
        t_tvalid = 1'b0;
        link_up  = 1'b1;
        @(posedge clk); #1;
        send_pkt(1'b0, 1, 32'h7000_0005);
        drain();
        check("t5_resume_dllp_cnt", 64'(dllp_cnt), 64'(d0 + CW'(1)));
        check("t5_resume_tlp_cnt", 64'(tlp_cnt), 64'(t0));

        // 17 single-beat DLLPs on a 4-bit counter wrap to 1
        do_reset();
        for (int i = 0; i < 17; i++) send_pkt(1'b0, 1, 32'h8000_0000 + 32'(i));
        drain();
        check("t6_wrap", 64'(dllp_cnt), 64'd1);
        check("t6_tlp_cnt", 64'(tlp_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phy_rx_stream_arbiter.md
Name: phy_rx_stream_arbiter

Overview:
Packet-level arbiter merging the receive-side DLLP and TLP AXI-Stream outputs of the PHY data handler into a single stream toward the data link layer. Grants whole packets round-robin, locks the grant until tlast, registers the output (one pipeline stage), and flushes both inputs while the link is down. Sits between the PHY receive path and the DLL receive front end, in the PHY receive clock domain.

Parameters:
DATA_WIDTH, 32, AXIS data width (bits)
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
USER_WIDTH, 5, tuser width, passed through unchanged
CNT_WIDTH, 16, width of packet counters

Ports:
clk_i  in  1  receive clock, all logic on rising edge
rst_n_i  in  1  reset, synchronous, active-low
link_up_i  in  1  PHY link up; low = flush
s_dllp_axis_tdata/tkeep/tvalid/tlast/tuser  in  DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH  DLLP source stream
s_dllp_axis_tready  out  1  DLLP source ready
s_tlp_axis_tdata/tkeep/tvalid/tlast/tuser  in  DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH  TLP source stream
s_tlp_axis_tready  out  1  TLP source ready
m_axis_tdata/tkeep/tvalid/tlast/tuser  out  DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH  merged output (registered)
m_axis_src_o  out  1  source of current output beat: 0 = DLLP, 1 = TLP
m_axis_tready  in  1  downstream ready
dllp_count_o  out  CNT_WIDTH  DLLP packets forwarded (tlast beats accepted), wraps
tlp_count_o  out  CNT_WIDTH  TLP packets forwarded, wraps

Behaviour:
- Reset (rst_n_i=0 at clk edge): state=IDLE, last_grant=TLP (DLLP wins first tie), all m_axis_* = 0, m_axis_src_o=0, counters=0, both s_*_tready=0.
- States: IDLE, GNT_DLLP, GNT_TLP, FLUSH.
- Output stage: out_ready = !m_axis_tvalid || m_axis_tready. A beat is accepted from the granted source when its tvalid && out_ready; it appears on m_axis_* the next cycle (latency 1). Full throughput: 1 beat/cycle while m_axis_tready=1.
- IDLE: grant decided combinationally the same cycle. One requester valid -> it wins. Both valid -> the one not equal to last_grant. Granted source's tready = out_ready, the other's = 0. If the first beat is accepted and tlast=0 -> GNT_x; if tlast=1 (single-beat packet) stay IDLE. last_grant updates on every accepted first beat.
- GNT_x: only source x has tready = out_ready; the other is held at 0 regardless of its tvalid. On accepted beat with tlast=1 -> IDLE; the next packet may start the following cycle (no bubble).
- Counters increment by 1 on each accepted tlast beat of their source, wrap from 2^CNT_WIDTH-1 to 0.
- m_axis_* holds stable while m_axis_tvalid=1 && m_axis_tready=0 (AXIS rule); m_axis_tvalid never drops without a handshake except on FLUSH entry.
- FLUSH: entered from any state when link_up_i=0. Both s_*_tready=1 (inputs drained and discarded); m_axis_tvalid cleared to 0 on entry; counters do not increment. Exit to IDLE on the first cycle link_up_i=1; last_grant is preserved.
- A packet interrupted by link down is truncated (no tlast emitted) unless the optional feature is on.
- Reset asserted mid-packet: immediate return to reset values; no partial-packet recovery.

Optional Feature:
PHY_RX_ARB_ABORT_EN. Defined: if link_up_i falls while in GNT_DLLP/GNT_TLP, the block first emits one abort beat (tdata=0, tkeep=0, tlast=1, tuser[0]=1, other tuser bits 0, m_axis_src_o = interrupted source), waits for its handshake with both s_*_tready=0, then enters FLUSH. Abort beats are not counted. Undefined: direct entry to FLUSH with truncation as above.

Decomposition:
- pcie_phy_pkg: arb_state_e enum (IDLE, GNT_DLLP, GNT_TLP, FLUSH, plus ABORT under the macro); localparam SRC_DLLP=1'b0, SRC_TLP=1'b1.
- One sub-module: axis_reg_slice (single-stage output register carrying data/keep/last/user/src with ready back-pressure), reusable elsewhere in the receive path.

Test Plan:
- Single DLLP: 2-beat packet on DLLP, tready=1 -> beats on m_axis at cycles +1,+2, src=0, tlast on beat 2, dllp_count_o=1.
- Tie: both sources valid from reset, TLP 4 beats, DLLP 2 beats, continuous -> DLLP packet first, then TLP with no bubble; a second tie grants DLLP again only after TLP was granted.
- Lock: DLLP asserts valid mid-TLP packet -> s_dllp_axis_tready stays 0 until the TLP tlast handshake, then DLLP is granted next cycle.
- Back-pressure: m_axis_tready toggles 1,0,0,1 during a 3-beat TLP -> output data stable while stalled, no beat lost or duplicated, tlp_count_o=1.
- Link down mid-TLP (beat 2 of 4) -> m_axis_tvalid=0 the next cycle, both treadys=1 while down, counts unchanged. With PHY_RX_ARB_ABORT_EN: one beat with tkeep=0, tlast=1, tuser=5'b00001 is emitted first.
- Counter wrap: CNT_WIDTH=4, 17 single-beat DLLPs -> dllp_count_o = 1.
